// File: rtl/display_scan_controller.sv
// Multiplexed 4-digit 7-segment scan controller with per-slot blanking, brightness PWM
// and a double-buffered image that is only swapped at frame boundaries.
module display_scan_controller #(
   parameter int CLK_DIV      = 100000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        upd_valid,
   output logic        upd_ready,
   input  logic [27:0] upd_seg,
   input  logic [3:0]  upd_mask,
   input  logic [2:0]  brightness,
   output logic        tic,
   output logic [1:0]  digit_sel,
   output logic [6:0]  CX,
   output logic [7:0]  An,
   output logic        frame_done
);

   localparam int UNIT = (CLK_DIV - BLANK_CYCLES) / 8;
   localparam int CW   = $clog2(CLK_DIV);

   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
   localparam logic [CW:0]   BLANK_W  = (CW+1)'(BLANK_CYCLES);

   localparam logic [1:0] ST_BLANK = 2'd0;
   localparam logic [1:0] ST_ON    = 2'd1;
   localparam logic [1:0] ST_OFF   = 2'd2;

   generate
      if (BLANK_CYCLES < 1 || CLK_DIV < BLANK_CYCLES + 8) begin : g_bad_params
         $error("display_scan_controller: need BLANK_CYCLES >= 1 and CLK_DIV >= BLANK_CYCLES + 8");
      end
   endgenerate

   logic [CW-1:0] cnt;
   logic [CW:0]   cnt_inc;
   logic [CW:0]   on_time;
   logic [1:0]    state;
   logic [1:0]    state_nxt;
   logic          slot_end;
   logic          pending;
   logic [27:0]   shadow_seg;
   logic [3:0]    shadow_mask;
   logic [27:0]   active_seg;
   logic [3:0]    active_mask;
   logic          capture;
   logic          show;
   logic [6:0]    cx_sel;

   // Handshake: an image transfers on any cycle where upd_valid and upd_ready are both high;
   // upd_ready is high whenever the shadow buffer holds no image waiting for a frame boundary.
   assign upd_ready = ~pending;
   assign capture   = upd_valid & ~pending;

   assign cnt_inc    = {1'b0, cnt} + (CW+1)'(1);
   assign slot_end   = (cnt == CNT_LAST);
   assign tic        = ~reset & slot_end;
   assign frame_done = tic & (digit_sel == 2'd3);

   // Slot FSM: next state is decided from the count value about to be entered.
   always_comb begin
      state_nxt = state;
      if (slot_end) begin
         state_nxt = ST_BLANK;
      end else if (cnt_inc == BLANK_W) begin
         state_nxt = ST_ON;
      end else if (state == ST_ON && cnt_inc == BLANK_W + on_time) begin
         state_nxt = ST_OFF;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt       <= '0;
         digit_sel <= 2'd0;
         state     <= ST_BLANK;
         on_time   <= (CW+1)'(UNIT);
      end else begin
         cnt   <= slot_end ? '0 : cnt_inc[CW-1:0];
         state <= state_nxt;
         if (slot_end) begin
            digit_sel <= digit_sel + 2'd1;
         end
         // Brightness is latched once per slot so a mid-slot change waits for the next slot.
         if (cnt == '0) begin
            on_time <= (CW+1)'(UNIT * (int'(brightness) + 1));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending     <= 1'b0;
         shadow_seg  <= {4{7'h7F}};
         shadow_mask <= 4'hF;
         active_seg  <= {4{7'h7F}};
         active_mask <= 4'hF;
      end else if (pending && frame_done) begin
         active_seg  <= shadow_seg;
         active_mask <= shadow_mask;
         pending     <= 1'b0;
      end else if (capture) begin
         shadow_seg  <= upd_seg;
         shadow_mask <= upd_mask;
         pending     <= 1'b1;
      end
   end

   always_comb begin
      cx_sel = 7'h7F;
      case (digit_sel)
         2'd0:    cx_sel = active_seg[6:0];
         2'd1:    cx_sel = active_seg[13:7];
         2'd2:    cx_sel = active_seg[20:14];
         default: cx_sel = active_seg[27:21];
      endcase
   end

   assign show = ~reset & (state == ST_ON) & active_mask[digit_sel];
   assign An   = show ? ~(8'h01 << digit_sel) : 8'hFF;
   assign CX   = show ? cx_sel : 7'h7F;

endmodule

// File: tb/tb_display_scan_controller.sv
// Randomized scoreboard bench for display_scan_controller: a cycle-time reference model
// predicts every output cycle, a negedge monitor pops and compares.
module tb_display_scan_controller;

  localparam int CLK_DIV = 20;
  localparam int BLANK   = 4;
  localparam int UNIT    = 2;
  localparam int FRAME   = 4 * CLK_DIV;

  logic        clk;
  logic        reset;
  logic        upd_valid;
  logic        upd_ready;
  logic [27:0] upd_seg;
  logic [3:0]  upd_mask;
  logic [2:0]  brightness;
  logic        tic;
  logic [1:0]  digit_sel;
  logic [6:0]  CX;
  logic [7:0]  An;
  logic        frame_done;

  display_scan_controller #(
    .CLK_DIV(CLK_DIV),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .clk(clk),
    .reset(reset),
    .upd_valid(upd_valid),
    .upd_ready(upd_ready),
    .upd_seg(upd_seg),
    .upd_mask(upd_mask),
    .brightness(brightness),
    .tic(tic),
    .digit_sel(digit_sel),
    .CX(CX),
    .An(An),
    .frame_done(frame_done)
  );

  // ---------------- clock / reset block ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    reset      = 1'b1;
    upd_valid  = 1'b0;
    upd_seg    = '0;
    upd_mask   = '0;
    brightness = '0;
  end

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [19:0] exp_q[$];
  int          time_q[$];

  // reference model: time since reset release plus the two image buffers
  int          t;
  bit          m_pending;
  logic [27:0] m_shadow_seg, m_active_seg;
  logic [3:0]  m_shadow_mask, m_active_mask;
  int          m_bright;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic model_reset();
    t             = 0;
    m_pending     = 1'b0;
    m_shadow_seg  = {4{7'h7F}};
    m_active_seg  = {4{7'h7F}};
    m_shadow_mask = 4'hF;
    m_active_mask = 4'hF;
    m_bright      = 0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [19:0] e;
      int          et;
      e  = exp_q.pop_front();
      et = time_q.pop_front();
      check($sformatf("scan_t%0d {An,CX,tic,fd,rdy,dsel}", et),
            {12'd0, An, CX, tic, frame_done, upd_ready, digit_sel}, {12'd0, e});
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1: drives one cycle, predicts its outputs, advances the model.
  task automatic step(input bit v, input logic [27:0] s, input logic [3:0] m, input int b);
    int          cnt, dig;
    bit          on, show, e_tic, e_fd;
    logic [7:0]  e_an;
    logic [6:0]  e_cx;
    upd_valid  = v;
    upd_seg    = s;
    upd_mask   = m;
    brightness = 3'(b);
    cnt = t % CLK_DIV;
    dig = (t / CLK_DIV) % 4;
    if (cnt == 0) m_bright = b;
    on    = (cnt >= BLANK) && (cnt < BLANK + UNIT * (m_bright + 1));
    show  = on && m_active_mask[dig];
    e_an  = 8'hFF;
    e_cx  = 7'h7F;
    if (show) begin
      e_an[dig] = 1'b0;
      e_cx      = m_active_seg[7*dig +: 7];
    end
    e_tic = (cnt == CLK_DIV - 1);
    e_fd  = e_tic && (dig == 3);
    exp_q.push_back({e_an, e_cx, e_tic, e_fd, !m_pending, 2'(dig)});
    time_q.push_back(t);
    if (m_pending && e_fd) begin
      m_active_seg  = m_shadow_seg;
      m_active_mask = m_shadow_mask;
      m_pending     = 1'b0;
    end else if (v && !m_pending) begin
      m_shadow_seg  = s;
      m_shadow_mask = m;
      m_pending     = 1'b1;
    end
    t++;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input int b);
    repeat (n) step(1'b0, 28'(0), 4'h0, b);
  endtask

  task automatic do_reset(input int n);
    upd_valid = 1'b0;
    reset     = 1'b1;
    repeat (n) begin
      @(negedge clk);
      check("reset_outs {An,CX,tic,fd}", {14'd0, An, CX, tic, frame_done},
            {14'd0, 8'hFF, 7'h7F, 2'b00});
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    model_reset();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  cur_b;
    bit  found;
    logic [27:0] seg_a;
    @(posedge clk);
    #1;
    do_reset(3);

    // known image, brightness 3
    step(1'b1, {7'h40, 7'h79, 7'h24, 7'h30}, 4'hF, 3);
    run(2 * FRAME, 3);

    // second offer while pending must be refused
    step(1'b1, 28'h1234567, 4'hF, 3);
    step(1'b1, 28'h7654321, 4'h3, 3);
    run(2 * FRAME, 3);

    // brightness extremes
    run(FRAME, 7);
    run(FRAME, 0);

    // masked digits 0 and 2
    step(1'b1, 28'(32'h0ABCDEF), 4'b1010, 5);
    run(2 * FRAME, 5);

    // capture on the frame_done cycle is deferred one frame
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      if ((t % FRAME) == FRAME - 1 && !m_pending) begin
        found = 1'b1;
        break;
      end
      step(1'b0, 28'(0), 4'h0, 4);
    end
    check("align_frame_done", 32'(found), 32'd1);
    step(1'b1, 28'h5A5A5A5, 4'hF, 4);
    run(2 * FRAME, 4);

    // reset mid-slot (digit 2, cnt 10) with an update pending
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      if ((t % FRAME) == 0 && !m_pending) begin
        found = 1'b1;
        break;
      end
      step(1'b0, 28'(0), 4'h0, 6);
    end
    check("align_frame_start", 32'(found), 32'd1);
    seg_a = 28'h0F0F0F0;
    step(1'b1, seg_a, 4'hF, 6);
    while ((t % FRAME) != 2 * CLK_DIV + 10) step(1'b0, 28'(0), 4'h0, 6);
    check("pending_before_reset", 32'(upd_ready), 32'd0);
    do_reset(2);
    run(2 * FRAME, 6);

    // randomized traffic
    cur_b = 2;
    for (int i = 0; i < 1600; i++) begin
      bit          v;
      logic [27:0] s;
      logic [3:0]  m;
      if ($urandom_range(0, 15) == 0) cur_b = $urandom_range(0, 7);
      v = ($urandom_range(0, 9) == 0);
      s = 28'($urandom());
      m = 4'($urandom_range(0, 15));
      step(v, s, m, cur_b);
    end

    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
